// File: rtl/fft_stage_seq_pkg.sv
// Shared types for the SDF stage sequencer: FSM states and the tag carried
// down the butterfly/multiplier delay line.
package fft_seq_pkg;

    localparam int FFT_HALF_DEPTH = 16;
    // Tag index field is sized for the largest supported half-frame; the
    // top truncates it back to IDX_W.
    localparam int TAG_IDX_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        BFLY = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [TAG_IDX_W-1:0] idx;
    } seq_tag_t;

endpackage

// File: rtl/fft_stage_seq_if.sv
// Control bundle between the stage sequencer (slave) and its upstream
// source / datapath observer (master). err exists only with FFT_STAGE_SEQ_ERR_EN.
interface fft_stage_seq_if #(
    parameter int IDX_W = 4
);
    logic             din_valid;
    logic             din_sof;
    logic             sr_en;
    logic             bf_en;
    logic             mul_en;
    logic [IDX_W-1:0] tw_idx;
    logic             dout_valid;
    logic             dout_sof;
    logic             dout_eof;
    logic             busy;
`ifdef FFT_STAGE_SEQ_ERR_EN
    logic             err;
`endif

    modport master (
        output din_valid, din_sof,
        input  sr_en, bf_en, mul_en, tw_idx, dout_valid, dout_sof, dout_eof, busy
`ifdef FFT_STAGE_SEQ_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  din_valid, din_sof,
        output sr_en, bf_en, mul_en, tw_idx, dout_valid, dout_sof, dout_eof, busy
`ifdef FFT_STAGE_SEQ_ERR_EN
        , output err
`endif
    );
endinterface

// File: rtl/fft_stage_seq_delay_line.sv
// Fixed-depth register pipeline for sequencer tags; advances every cycle,
// so stalled input cycles appear as bubbles at the output.
module seq_delay_line
    import fft_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rstn,
    input  seq_tag_t tag_i,
    output seq_tag_t tag_o
);

    seq_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_seq.sv
// Handshake-driven frame sequencer for one radix-2 SDF FFT stage.
// Optional sticky protocol error output: define FFT_STAGE_SEQ_ERR_EN.
module fft_stage_seq
    import fft_seq_pkg::*;
#(
    parameter int HALF_DEPTH = FFT_HALF_DEPTH,
    parameter int BF_LAT     = 1,
    parameter int MUL_LAT    = 1,
    parameter int IDX_W      = $clog2(HALF_DEPTH)
) (
    input  logic           clk,
    input  logic           rstn,
    fft_stage_seq_if.slave io
);

    seq_state_e       state_q;
    logic [IDX_W-1:0] cnt_q;
    logic             busy_q;
    logic             acc;
    logic             last_beat;
    logic             bf_en;
    seq_tag_t         bf_tag, mul_tag, out_tag;

    // Gated by rstn so the combinational enables also read 0 while in reset.
    assign acc       = rstn && io.din_valid && (state_q != IDLE || io.din_sof);
    assign last_beat = (cnt_q == IDX_W'(HALF_DEPTH - 1));
    assign bf_en     = acc && (state_q == BFLY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (acc) begin
            // Power-of-two half-frame: the counter wraps to 0 on the last beat.
            cnt_q <= cnt_q + IDX_W'(1);
            unique case (state_q)
                IDLE: begin
                    state_q <= FILL;
                    busy_q  <= 1'b1;
                end
                FILL: if (last_beat) state_q <= BFLY;
                BFLY: if (last_beat) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bf_tag = '0;
        if (bf_en) begin
            bf_tag.valid = 1'b1;
            bf_tag.first = (cnt_q == '0);
            bf_tag.last  = last_beat;
            bf_tag.idx   = TAG_IDX_W'(cnt_q);
        end
    end

    seq_delay_line #(.DEPTH(BF_LAT)) u_bf_dly (
        .clk   (clk),
        .rstn  (rstn),
        .tag_i (bf_tag),
        .tag_o (mul_tag)
    );

    seq_delay_line #(.DEPTH(MUL_LAT)) u_mul_dly (
        .clk   (clk),
        .rstn  (rstn),
        .tag_i (mul_tag),
        .tag_o (out_tag)
    );

    assign io.sr_en      = acc;
    assign io.bf_en      = bf_en;
    assign io.mul_en     = mul_tag.valid;
    assign io.tw_idx     = mul_tag.idx[IDX_W-1:0];
    assign io.dout_valid = out_tag.valid;
    assign io.dout_sof   = out_tag.valid && out_tag.first;
    assign io.dout_eof   = out_tag.valid && out_tag.last;
    assign io.busy       = busy_q;

`ifdef FFT_STAGE_SEQ_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                               err_q <= 1'b0;
        else if (io.din_valid && io.din_sof && state_q != IDLE) err_q <= 1'b1;
    end

    assign io.err = err_q;
`endif

endmodule
